mem_bus_responder: RTL and testbench

//  Memory-side responder for the CPU's instruction and data strobe/ack buses.

---
 rtl/mem_bus_responder.sv | 138 +++++++++++++
 tb/tb_mem_bus_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - instruction/data strobe-ack responder sharing one single-port word array
module mem_bus_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_stb_i,
    input  logic              instr_we_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    input  logic [DATA_W-1:0] instr_dat_i,
    output logic [DATA_W-1:0] instr_dat_o,
    output logic              instr_ack_o,
    input  logic              data_stb_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_dat_i,
    output logic [DATA_W-1:0] data_dat_o,
    output logic              data_ack_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam int         IDX_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LAST   = 4'(WAIT_CYCLES - 1);
    localparam logic       GRANT_INSTR = 1'b0;
    localparam logic       GRANT_DATA  = 1'b1;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic [DATA_W-1:0]   instr_dat_q, instr_dat_d;
    logic [DATA_W-1:0]   data_dat_q, data_dat_d;

    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
    logic                in_range;
    logic [DATA_W-1:0]   rd_data;
    logic                gnt;

    assign in_range = 32'(addr_q) < 32'(MEM_DEPTH);
    assign rd_data  = in_range ? mem_q[addr_q[IDX_W-1:0]] : '0;
    assign busy_o   = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdat_d       = wdat_q;
        instr_dat_d  = instr_dat_q;
        data_dat_d   = data_dat_q;
        instr_ack_o  = 1'b0;
        data_ack_o   = 1'b0;
        instr_dat_o  = instr_dat_q;
        data_dat_o   = data_dat_q;
        gnt          = GRANT_INSTR;

        case (state_q)
            S_IDLE: begin
                if (instr_stb_i || data_stb_i) begin
                    // On a tie the port that lost the previous grant goes first.
                    if (instr_stb_i && data_stb_i)
                        gnt = (last_grant_q == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
                    else
                        gnt = data_stb_i ? GRANT_DATA : GRANT_INSTR;
                    grant_d      = gnt;
                    last_grant_d = gnt;
                    addr_d       = (gnt == GRANT_DATA) ? data_addr_i : instr_addr_i;
                    we_d         = (gnt == GRANT_DATA) ? data_we_i   : instr_we_i;
                    wdat_d       = (gnt == GRANT_DATA) ? data_dat_i  : instr_dat_i;
                    cnt_d        = 4'd0;
                    state_d      = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                if (grant_q == GRANT_DATA) begin
                    data_ack_o = 1'b1;
                    data_dat_o = rd_data;
                    data_dat_d = rd_data;
                end else begin
                    instr_ack_o = 1'b1;
                    instr_dat_o = rd_data;
                    instr_dat_d = rd_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= GRANT_INSTR;
            grant_q      <= GRANT_INSTR;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdat_q       <= '0;
            instr_dat_q  <= '0;
            data_dat_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdat_q       <= wdat_d;
            instr_dat_q  <= instr_dat_d;
            data_dat_q   <= data_dat_d;
        end
    end

    // Array keeps its contents across reset; an aborted transaction never reaches S_ACK.
    always_ff @(posedge clk) begin
        if (state_q == S_ACK && we_q && in_range)
            mem_q[addr_q[IDX_W-1:0]] <= wdat_q;
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed bench over four parameterisations of mem_bus_responder
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_stb = 1'b0, instr_we = 1'b0, data_stb = 1'b0, data_we = 1'b0;
    logic [10:0] ia = '0, da = '0;
    logic [15:0] idi = '0, ddi = '0;

    logic [3:0]  iack, dack, busy;
    logic [15:0] idat [4];
    logic [15:0] ddat [4];

    int          checks = 0;
    int          errors = 0;
    int          lat [4];
    logic [15:0] rd [4];
    logic        overlap_seen = 1'b0;

    always #5 clk = ~clk;

    // idx0: WAIT=1, idx1: WAIT=0, idx2: WAIT=15, idx3: WAIT=1 with MEM_DEPTH=1000 and 11-bit addresses
    mem_bus_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .instr_stb_i(instr_stb), .instr_we_i(instr_we), .instr_addr_i(ia[9:0]), .instr_dat_i(idi),
        .instr_dat_o(idat[0]), .instr_ack_o(iack[0]),
        .data_stb_i(data_stb), .data_we_i(data_we), .data_addr_i(da[9:0]), .data_dat_i(ddi),
        .data_dat_o(ddat[0]), .data_ack_o(dack[0]), .busy_o(busy[0]));

    mem_bus_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .instr_stb_i(instr_stb), .instr_we_i(instr_we), .instr_addr_i(ia[9:0]), .instr_dat_i(idi),
        .instr_dat_o(idat[1]), .instr_ack_o(iack[1]),
        .data_stb_i(data_stb), .data_we_i(data_we), .data_addr_i(da[9:0]), .data_dat_i(ddi),
        .data_dat_o(ddat[1]), .data_ack_o(dack[1]), .busy_o(busy[1]));

    mem_bus_responder #(.WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst_n(rst_n),
        .instr_stb_i(instr_stb), .instr_we_i(instr_we), .instr_addr_i(ia[9:0]), .instr_dat_i(idi),
        .instr_dat_o(idat[2]), .instr_ack_o(iack[2]),
        .data_stb_i(data_stb), .data_we_i(data_we), .data_addr_i(da[9:0]), .data_dat_i(ddi),
        .data_dat_o(ddat[2]), .data_ack_o(dack[2]), .busy_o(busy[2]));

    mem_bus_responder #(.ADDR_W(11), .MEM_DEPTH(1000), .WAIT_CYCLES(1)) u_d1000 (
        .clk(clk), .rst_n(rst_n),
        .instr_stb_i(instr_stb), .instr_we_i(instr_we), .instr_addr_i(ia), .instr_dat_i(idi),
        .instr_dat_o(idat[3]), .instr_ack_o(iack[3]),
        .data_stb_i(data_stb), .data_we_i(data_we), .data_addr_i(da), .data_dat_i(ddi),
        .data_dat_o(ddat[3]), .data_ack_o(dack[3]), .busy_o(busy[3]));

    always @(negedge clk) if (|(iack & dack)) overlap_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request presented for a single IDLE cycle; latency counted in cycles after that one.
    task automatic do_req(input logic port, input logic we, input logic [10:0] addr, input logic [15:0] wd);
        for (int i = 0; i < 4; i++) begin lat[i] = -1; rd[i] = '0; end
        @(posedge clk); #1;
        if (port) begin data_stb = 1'b1; data_we = we; da = addr; ddi = wd; end
        else      begin instr_stb = 1'b1; instr_we = we; ia = addr; idi = wd; end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            instr_stb = 1'b0; data_stb = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if ((port ? dack[i] : iack[i]) && lat[i] < 0) begin
                    lat[i] = k;
                    rd[i]  = port ? ddat[i] : idat[i];
                end
            end
        end
    endtask

    int          acks;
    int          n;
    int          rr_k [4];
    logic        rr_d [4];
    logic [10:0] step_addr [3];
    logic [15:0] step_exp [3];

    initial begin
        step_addr[0] = 11'd1023; step_addr[1] = 11'd5; step_addr[2] = 11'd7;
        step_exp[0]  = 16'h5A5A; step_exp[1]  = 16'hBEEF; step_exp[2] = 16'h1111;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_iack", iack[0], 0);
        check("rst_dack", dack[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_idat", idat[0], 0);
        check("rst_ddat", ddat[0], 0);
        @(posedge clk); #1 rst_n = 1'b1;

        do_req(1'b1, 1'b1, 11'd5, 16'hBEEF);
        check("lat_w1", lat[0], 2);
        check("lat_w0", lat[1], 1);
        check("lat_w15", lat[2], 16);
        check("lat_d1000", lat[3], 2);
        do_req(1'b1, 1'b0, 11'd5, 16'h0);
        check("rd5_w1", rd[0], 16'hBEEF);
        check("rd5_w0", rd[1], 16'hBEEF);
        check("rd5_w15", rd[2], 16'hBEEF);

        do_req(1'b0, 1'b1, 11'd1023, 16'h5A5A);
        do_req(1'b0, 1'b0, 11'd1023, 16'h0);
        check("rd1023_w1", rd[0], 16'h5A5A);
        check("rd1023_oor_lat", lat[3], 2);
        check("rd1023_oor_dat", rd[3], 0);

        do_req(1'b1, 1'b1, 11'd999, 16'h0999);
        do_req(1'b1, 1'b0, 11'd999, 16'h0);
        check("rd999_d1000", rd[3], 16'h0999);
        do_req(1'b1, 1'b1, 11'd0, 16'h0F0F);
        do_req(1'b1, 1'b1, 11'd1024, 16'hAAAA);
        check("wr1024_lat", lat[3], 2);
        do_req(1'b0, 1'b0, 11'd1024, 16'h0);
        check("rd1024_lat", lat[3], 2);
        check("rd1024_dat", rd[3], 0);
        do_req(1'b0, 1'b0, 11'd0, 16'h0);
        check("rd0_no_alias", rd[3], 16'h0F0F);

        // Reset during WAIT of a write must abort it.
        do_req(1'b1, 1'b1, 11'd7, 16'h1111);
        @(posedge clk); #1;
        data_stb = 1'b1; data_we = 1'b1; da = 11'd7; ddi = 16'h1234;
        @(posedge clk); #1;
        data_stb = 1'b0; data_we = 1'b0;
        #2 rst_n = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (iack[0] || dack[0] || iack[2] || dack[2]) acks++;
        end
        check("abort_no_ack", acks, 0);
        check("abort_busy", busy[0], 0);
        check("abort_ddat_clr", ddat[0], 0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_req(1'b1, 1'b0, 11'd7, 16'h0);
        check("abort_rd7_w1", rd[0], 16'h1111);
        check("abort_rd7_w15", rd[2], 16'h1111);

        // Both strobes held from reset release: data wins first tie, then alternation.
        @(posedge clk); #1 rst_n = 1'b0;
        instr_stb = 1'b1; instr_we = 1'b0; ia = 11'd1023;
        data_stb  = 1'b1; data_we  = 1'b0; da = 11'd5;
        @(posedge clk); #1 rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if ((iack[0] || dack[0]) && n < 4) begin
                rr_k[n] = k;
                rr_d[n] = dack[0];
                if (iack[0]) check("rr_hold_ddat", ddat[0], 16'hBEEF);
                n++;
            end
        end
        instr_stb = 1'b0; data_stb = 1'b0;
        check("rr_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            check("rr_time", (i < n) ? rr_k[i] : -1, 2 + 3 * i);
            check("rr_port", (i < n) ? rr_d[i] : 1'bx, (i % 2 == 0) ? 1 : 0);
        end
        repeat (20) @(posedge clk);

        // Instr strobe held continuously, address stepped after each ack.
        @(posedge clk); #1;
        instr_stb = 1'b1; instr_we = 1'b0; ia = step_addr[0];
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (iack[0] && n < 3) begin
                check("held_time", k, 2 + 3 * n);
                check("held_dat", idat[0], step_exp[n]);
                n++;
                if (n < 3) ia = step_addr[n];
            end
        end
        instr_stb = 1'b0;
        check("held_count", n, 3);
        repeat (20) @(posedge clk);

        check("no_ack_overlap", overlap_seen, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
